// File: rtl/decode_stage_p_pkg.sv
// decode_pkg: opcodes, control-field layout and opcode-to-control decode for decode_stage_p.
package decode_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam int DE_W = 2;
    localparam int EX_W = 4;
    localparam int M_W = 2;
    localparam int WB_W = 2;
    localparam int DE_BRANCH = 1;
    localparam int DE_BNE = 0;
    localparam int EX_REGDST = 3;
    localparam int M_READ = 1;
    localparam int WB_REGWRITE = 1;

    // EX = {reg_dst, alu_op[1:0], alu_src}; use_rs/use_rt mark which source fields are consumed
    typedef struct packed {
        logic [DE_W-1:0] de;
        logic [EX_W-1:0] ex;
        logic [M_W-1:0] m;
        logic [WB_W-1:0] wb;
        logic use_rs;
        logic use_rt;
    } ctrl_t;

    function automatic ctrl_t decode_op(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: c = '{de: 2'b00, ex: 4'b1100, m: 2'b00, wb: 2'b10, use_rs: 1'b1, use_rt: 1'b1};
            OP_LW:    c = '{de: 2'b00, ex: 4'b0001, m: 2'b10, wb: 2'b11, use_rs: 1'b1, use_rt: 1'b0};
            OP_SW:    c = '{de: 2'b00, ex: 4'b0001, m: 2'b01, wb: 2'b00, use_rs: 1'b1, use_rt: 1'b1};
            OP_BEQ:   c = '{de: 2'b10, ex: 4'b0010, m: 2'b00, wb: 2'b00, use_rs: 1'b1, use_rt: 1'b1};
            OP_BNE:   c = '{de: 2'b11, ex: 4'b0010, m: 2'b00, wb: 2'b00, use_rs: 1'b1, use_rt: 1'b1};
            OP_ADDI:  c = '{de: 2'b00, ex: 4'b0001, m: 2'b00, wb: 2'b10, use_rs: 1'b1, use_rt: 1'b0};
            default:  c = '0;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/decode_stage_p_if.sv
// decode_stage_p_if: IF/ID inputs, write-back and EX/MEM info, hazard outputs and ID/EX contents.
interface decode_stage_p_if
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W = 10,
    parameter int NREGS = 32
);
    localparam int RA_W = $clog2(NREGS);
    logic if_valid;
    logic [31:0] instruc;
    logic [PC_W-1:0] current_PC;
    logic reg_write;
    logic [RA_W-1:0] rw;
    logic [DATA_W-1:0] busw;
    logic exmem_regwrite;
    logic [RA_W-1:0] exmem_rd;
    logic [DATA_W-1:0] exmem_result;
    logic stall;
    logic if_flush;
    logic branch_sel;
    logic [PC_W-1:0] jump_address;
    logic idex_valid;
    logic [EX_W-1:0] EX_control;
    logic [M_W-1:0] M_control;
    logic [WB_W-1:0] WB_control;
    logic [DATA_W-1:0] bus_a;
    logic [DATA_W-1:0] bus_b;
    logic [DATA_W-1:0] immed_ext;
    logic [RA_W-1:0] idex_rt;
    logic [RA_W-1:0] idex_rd;

    modport master (
        output if_valid, instruc, current_PC, reg_write, rw, busw, exmem_regwrite, exmem_rd, exmem_result,
        input stall, if_flush, branch_sel, jump_address, idex_valid, EX_control, M_control, WB_control,
        input bus_a, bus_b, immed_ext, idex_rt, idex_rd
    );
    modport slave (
        input if_valid, instruc, current_PC, reg_write, rw, busw, exmem_regwrite, exmem_rd, exmem_result,
        output stall, if_flush, branch_sel, jump_address, idex_valid, EX_control, M_control, WB_control,
        output bus_a, bus_b, immed_ext, idex_rt, idex_rd
    );
endinterface

// File: rtl/decode_stage_p_hazard_unit.sv
// hazard_unit_p: load-use and branch-operand stall detection plus branch forwarding selects.
// ID_BRANCH_FWD_EN: forward EX/MEM into the branch comparator instead of stalling on it.
module hazard_unit_p #(
    parameter int RA_W = 5
) (
    input logic if_valid,
    input logic branch,
    input logic use_rs,
    input logic use_rt,
    input logic [RA_W-1:0] rs,
    input logic [RA_W-1:0] rt,
    input logic idex_valid,
    input logic idex_load,
    input logic idex_regwrite,
    input logic [RA_W-1:0] idex_rt,
    input logic [RA_W-1:0] idex_dest,
    input logic mem_load,
    input logic [RA_W-1:0] mem_rt,
    input logic exmem_regwrite,
    input logic [RA_W-1:0] exmem_rd,
    output logic stall,
    output logic fwd_a,
    output logic fwd_b
);
    logic load_use, ex_hit, mem_ld_hit, exmem_hit;

    function automatic logic src_hit(input logic [RA_W-1:0] d, input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
        return d != '0 && (d == a || d == b);
    endfunction

    always_comb begin
        load_use = idex_valid & idex_load & ((use_rs & idex_rt == rs) | (use_rt & idex_rt == rt));
        ex_hit = idex_valid & idex_regwrite & src_hit(idex_dest, rs, rt);
        // a load now in MEM has no value on exmem_result yet, so it always holds a branch
        mem_ld_hit = mem_load & src_hit(mem_rt, rs, rt);
`ifdef ID_BRANCH_FWD_EN
        exmem_hit = 1'b0;
        fwd_a = exmem_regwrite && exmem_rd != '0 && exmem_rd == rs;
        fwd_b = exmem_regwrite && exmem_rd != '0 && exmem_rd == rt;
`else
        exmem_hit = exmem_regwrite & src_hit(exmem_rd, rs, rt);
        fwd_a = 1'b0;
        fwd_b = 1'b0;
`endif
        stall = if_valid & (load_use | (branch & (ex_hit | mem_ld_hit | exmem_hit)));
    end
endmodule

// File: rtl/decode_stage_p.sv
// decode_stage_p: ID stage with register file, BEQ/BNE resolution, hazard stalls and ID/EX register.
// ID_BRANCH_FWD_EN: branch comparands may be forwarded from exmem_result.
module decode_stage_p
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W = 10,
    parameter int NREGS = 32
) (
    input logic clock,
    input logic reset,
    decode_stage_p_if.slave bus
);
    localparam int RA_W = $clog2(NREGS);
    logic [DATA_W-1:0] regs [NREGS];
    ctrl_t c;
    logic [RA_W-1:0] rs, rt, idex_dest, mem_ld_rt;
    logic [DATA_W-1:0] imm, rd_a, rd_b, cmp_a, cmp_b;
    logic stall_raw, fwd_a, fwd_b, issue, mem_ld_valid;

    assign c = decode_op(bus.instruc[31:26]);
    assign rs = bus.instruc[21 +: RA_W];
    assign rt = bus.instruc[16 +: RA_W];
    assign imm = {{(DATA_W-16){bus.instruc[15]}}, bus.instruc[15:0]};
    assign rd_a = rs == '0 ? '0 : (bus.reg_write && bus.rw == rs) ? bus.busw : regs[rs];
    assign rd_b = rt == '0 ? '0 : (bus.reg_write && bus.rw == rt) ? bus.busw : regs[rt];
    assign idex_dest = bus.EX_control[EX_REGDST] ? bus.idex_rd : bus.idex_rt;

    hazard_unit_p #(.RA_W(RA_W)) u_hazard (
        .if_valid(bus.if_valid),
        .branch(c.de[DE_BRANCH]),
        .use_rs(c.use_rs),
        .use_rt(c.use_rt),
        .rs(rs),
        .rt(rt),
        .idex_valid(bus.idex_valid),
        .idex_load(bus.M_control[M_READ]),
        .idex_regwrite(bus.WB_control[WB_REGWRITE]),
        .idex_rt(bus.idex_rt),
        .idex_dest(idex_dest),
        .mem_load(mem_ld_valid),
        .mem_rt(mem_ld_rt),
        .exmem_regwrite(bus.exmem_regwrite),
        .exmem_rd(bus.exmem_rd),
        .stall(stall_raw),
        .fwd_a(fwd_a),
        .fwd_b(fwd_b)
    );

    always_comb begin
        cmp_a = fwd_a ? bus.exmem_result : rd_a;
        cmp_b = fwd_b ? bus.exmem_result : rd_b;
        bus.stall = stall_raw & ~reset;
        issue = bus.if_valid & ~bus.stall;
        bus.branch_sel = issue & c.de[DE_BRANCH] & (c.de[DE_BNE] ? cmp_a != cmp_b : cmp_a == cmp_b);
        bus.if_flush = bus.branch_sel;
        bus.jump_address = bus.current_PC + imm[PC_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (bus.reg_write && bus.rw != '0) begin
            regs[bus.rw] <= bus.busw;
        end
    end

    // bubbles clear the whole entry; mem_ld_* tracks whether the entry leaving ID/EX was a load
    always_ff @(posedge clock) begin
        if (reset || !issue) begin
            bus.idex_valid <= 1'b0;
            bus.EX_control <= '0;
            bus.M_control <= '0;
            bus.WB_control <= '0;
            bus.bus_a <= '0;
            bus.bus_b <= '0;
            bus.immed_ext <= '0;
            bus.idex_rt <= '0;
            bus.idex_rd <= '0;
        end else begin
            bus.idex_valid <= 1'b1;
            bus.EX_control <= c.ex;
            bus.M_control <= c.m;
            bus.WB_control <= c.wb;
            bus.bus_a <= rd_a;
            bus.bus_b <= rd_b;
            bus.immed_ext <= imm;
            bus.idex_rt <= rt;
            bus.idex_rd <= bus.instruc[11 +: RA_W];
        end
        mem_ld_valid <= !reset && bus.idex_valid && bus.M_control[M_READ];
        mem_ld_rt <= reset ? '0 : bus.idex_rt;
    end
endmodule

// File: doc/decode_stage_p.md
# decode_stage_p

Parametrised decode stage for the five-stage MIPS/DLX pipeline, sitting between the fetch stage and the ALU stage. It decodes the instruction, reads the register file, and resolves BEQ/BNE in ID. It owns the ID/EX pipeline register and detects load-use and branch-operand hazards, stalling fetch and inserting bubbles into EX as required. Register width, PC width and register count are generic.

## Interface
- DATA_W, 32: register/data width
- PC_W, 10: program-counter width
- NREGS, 32: register-file depth (power of two); address width RA_W = log2(NREGS)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- if_valid  in  1  instruc/current_PC hold a real instruction
- instruc  in  32  instruction in ID
- current_PC  in  PC_W  PC+1 of instruc
- reg_write, rw, busw  in  1/RA_W/DATA_W  write-back port
- exmem_regwrite, exmem_rd, exmem_result  in  1/RA_W/DATA_W  EX/MEM producer info
- stall  out  1  hold PC and IF/ID
- if_flush  out  1  squash the IF/ID entry
- branch_sel  out  1  take jump_address
- jump_address  out  PC_W  branch target
- idex_valid, EX_control[3:0], M_control[1:0], WB_control[1:0], bus_a, bus_b, immed_ext, idex_rt, idex_rd  out  registered ID/EX contents

## Operation
- Decode: the opcode in instruc[31:26] maps to DE/EX/M/WB controls through package constants.
  - M_control = {mem_read, mem_write}.
  - WB_control = {reg_write, mem_to_reg}.
  - DE_control = {branch, bne}.
- immed_ext: sign extension of instruc[15:0] to DATA_W.
- jump_address: current_PC + immed_ext[PC_W-1:0], modulo 2^PC_W, so it wraps.
- Register file:
  - Register 0 always reads as 0; writes to it are ignored.
  - Write-before-read bypass: a read with ra == rw and reg_write set returns busw in the same cycle.
- Load-use hazard: stall=1 when idex_valid & M_control[1] & idex_rt ∈ {rs, rt of a consumer}.
- Branch hazard: stall=1 when a valid branch has a source equal to a nonzero rd/rt still in flight. Which stages count is set by ID_BRANCH_FWD_EN (see Configuration).
- Stall cycle behaviour:
  - The ID/EX register loads a bubble: idex_valid=0 and all controls 0.
  - The ID inputs must be held by the upstream stage.
  - branch_sel=0 while the stall is asserted.
- Branch resolution: branch_sel = if_valid & branch & ~stall & (bne ? a≠b : a==b).
- if_flush = branch_sel; no delay slot.
- An invalid input (if_valid=0) produces a bubble and never stalls.

## Timing
- Reset: every ID/EX output is 0, and the register file is cleared to 0.
- stall, branch_sel, if_flush and jump_address are combinational from the current inputs and ID/EX state.
- ID/EX updates on every clock edge with a decoded instruction or a bubble; latency is 1 cycle.
- Stall lengths:
  - Load-use costs exactly 1 bubble.
  - Branch dependent on a load in ID/EX costs 2 bubbles.
  - Branch dependent on an ALU result in ID/EX costs 1 bubble when forwarding is on, 2 when it is off.
- Reset asserted mid-stall: the stall is dropped and the ID/EX register is cleared on that edge.
- Simultaneous write-back and read: the bypass value is used.

## Configuration
- ID_BRANCH_FWD_EN defined:
  - Branch comparands come from exmem_result when exmem_regwrite & exmem_rd == source & source ≠ 0.
  - Only ID/EX producers stall a branch.
- ID_BRANCH_FWD_EN undefined:
  - exmem_* ports are still present but unused for forwarding.
  - An EX/MEM producer matching a branch source also stalls the branch.

## Structure
- Package decode_pkg holds:
  - opcode localparams (R-type, LW, SW, BEQ, BNE, ADDI);
  - control-field widths and bit indices;
  - the opcode-to-control function.
- One sub-module, hazard_unit_p: combinational; produces stall and the forwarding selects.
- Register file and ID/EX register are inline.

## Test plan
- Reset held for 3 cycles, then released → all ID/EX outputs 0, stall=0, branch_sel=0.
- Write-back busw=0x1234 to r5, with instruc reading r5 as rs in the same cycle → bus_a=0x1234 after the next edge.
- LW r3 followed by ADD r4,r3,r2 → stall=1 for one cycle, one bubble (idex_valid=0), then the ADD is issued.
- BEQ r1,r1 with immed=-2 at current_PC=0x001 → branch_sel=1, if_flush=1, jump_address=0x3FF (wrap).
- ADD r6 in ID/EX followed by BNE r6,r0:
  - macro on → 1 stall, then the forwarded exmem_result is compared;
  - macro off → 2 stalls.
- Writing r0 with busw=0xFFFFFFFF, then reading r0 → 0.
